// File: rtl/regfile_write_arbiter.sv
// Two-requester write-back arbiter for the register file write port.
// Per-requester FIFOs drained round-robin into registered RF write signals.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              MEM_VALID,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_READY,
    output logic              RF_WRITE,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic [DATA_W-1:0] RF_DATA,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              RD1_BUSY,
    output logic              RD2_BUSY
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ALU = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    // Index 0 is the ALU requester, index 1 the MEM requester.
    logic [ADDR_W-1:0] addr_q [2][QDEPTH];
    logic [DATA_W-1:0] data_q [2][QDEPTH];
    logic [QDEPTH-1:0] vld_q [2];
    logic [QDEPTH-1:0] vld_d [2];
    logic [PW-1:0]     head_q [2];
    logic [PW-1:0]     head_d [2];
    logic [PW-1:0]     tail_q [2];
    logic [PW-1:0]     tail_d [2];
    logic [CW-1:0]     cnt_q [2];
    logic [CW-1:0]     cnt_d [2];

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        req, rdy, push, pop, nonempty;

    always_comb begin
        in_addr[0] = ALU_ADDR;
        in_addr[1] = MEM_ADDR;
        in_data[0] = ALU_DATA;
        in_data[1] = MEM_DATA;
        req        = {MEM_VALID, ALU_VALID};
        for (int r = 0; r < 2; r++) begin
            rdy[r]      = cnt_q[r] < CW'(QDEPTH);
            nonempty[r] = cnt_q[r] != '0;
            // x0 writes complete the handshake but are never queued
            push[r]     = req[r] && rdy[r] && (in_addr[r] != '0) && !FLUSH;
        end
    end

    always_comb begin
        state_d   = IDLE;
        last_d    = last_q;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (!FLUSH) begin
            unique case (1'b1)
                nonempty[0] && nonempty[1]:  state_d = last_q ? GNT_ALU : GNT_MEM;
                nonempty[0] && !nonempty[1]: state_d = GNT_ALU;
                !nonempty[0] && nonempty[1]: state_d = GNT_MEM;
                default:                     state_d = IDLE;
            endcase
        end
        pop[0] = state_d == GNT_ALU;
        pop[1] = state_d == GNT_MEM;
        for (int r = 0; r < 2; r++) begin
            if (pop[r]) begin
                last_d    = (r == 1);
                rf_addr_d = addr_q[r][head_q[r]];
                rf_data_d = data_q[r][head_q[r]];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            vld_d[r]  = vld_q[r];
            head_d[r] = head_q[r];
            tail_d[r] = tail_q[r];
            cnt_d[r]  = cnt_q[r];
            if (FLUSH) begin
                vld_d[r]  = '0;
                head_d[r] = '0;
                tail_d[r] = '0;
                cnt_d[r]  = '0;
            end else begin
                if (push[r]) begin
                    vld_d[r][tail_q[r]] = 1'b1;
                    tail_d[r] = tail_q[r] + PW'(1);
                end
                if (pop[r]) begin
                    vld_d[r][head_q[r]] = 1'b0;
                    head_d[r] = head_q[r] + PW'(1);
                end
                cnt_d[r] = cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            for (int r = 0; r < 2; r++) begin
                vld_q[r]  <= '0;
                head_q[r] <= '0;
                tail_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            for (int r = 0; r < 2; r++) begin
                vld_q[r]  <= vld_d[r];
                head_q[r] <= head_d[r];
                tail_q[r] <= tail_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    // Payload storage needs no reset: slot contents are qualified by vld_q
    always_ff @(posedge CLK) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                addr_q[r][tail_q[r]] <= in_addr[r];
                data_q[r][tail_q[r]] <= in_data[r];
            end
        end
    end

    logic hit1, hit2;

    always_comb begin
        hit1 = (state_q != IDLE) && (rf_addr_q == RD1_ADDR);
        hit2 = (state_q != IDLE) && (rf_addr_q == RD2_ADDR);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (vld_q[r][i] && addr_q[r][i] == RD1_ADDR) hit1 = 1'b1;
                if (vld_q[r][i] && addr_q[r][i] == RD2_ADDR) hit2 = 1'b1;
            end
        end
    end

    assign ALU_READY = rdy[0];
    assign MEM_READY = rdy[1];
    assign RF_WRITE  = state_q != IDLE;
    assign RF_ADDR   = rf_addr_q;
    assign RF_DATA   = rf_data_q;
    assign RD1_BUSY  = hit1 && (RD1_ADDR != '0);
    assign RD2_BUSY  = hit2 && (RD2_ADDR != '0);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: the ALU pipe and the load/memory unit.
- Each requester has its own small FIFO. A round-robin arbiter drains one entry per cycle into registered write-port signals.
- Per-register pending flags tell the hazard unit which source registers still have uncommitted writes.
- Sits between the write-back stage and the register file's WRITE/INADDRESS/IN inputs.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
QDEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
FLUSH  input  1  synchronous, drops all queued entries
ALU_VALID  input  1  ALU write request
ALU_ADDR  input  ADDR_W  ALU destination register
ALU_DATA  input  DATA_W  ALU result
ALU_READY  output  1  ALU FIFO can accept
MEM_VALID  input  1  load write request
MEM_ADDR  input  ADDR_W  load destination register
MEM_DATA  input  DATA_W  load data
MEM_READY  output  1  MEM FIFO can accept
RF_WRITE  output  1  register file write enable
RF_ADDR  output  ADDR_W  register file INADDRESS
RF_DATA  output  DATA_W  register file IN
RD1_ADDR  input  ADDR_W  hazard query address 1
RD2_ADDR  input  ADDR_W  hazard query address 2
RD1_BUSY  output  1  query 1 has a pending write
RD2_BUSY  output  1  query 2 has a pending write

Behaviour:
- Reset (RESET=0, asynchronous):
  - both FIFOs empty, counts 0;
  - RF_WRITE=0, RF_ADDR=0, RF_DATA=0;
  - round-robin pointer LAST=ALU, so MEM wins the first tie;
  - ALU_READY=MEM_READY=1 once RESET=1.
  - Reset mid-operation discards all queued writes with no partial RF write.
- Handshake:
  - Transfer occurs at a rising edge with X_VALID=1 and X_READY=1.
  - X_READY = (count_X < QDEPTH). It is derived from registered count only, with no combinational path from a same-cycle pop. A full FIFO being popped still shows READY=0.
- x0 writes: a request with ADDR=0 is accepted (handshake completes) but never enqueued and never reaches RF.
- FIFO: circular buffer, head/tail pointers wrap modulo QDEPTH. Push and pop in the same cycle keep the count unchanged.
- Arbiter, per edge, when FLUSH=0:
  - neither FIFO non-empty -> no pop, RF_WRITE<=0;
  - one non-empty -> pop its head;
  - both non-empty -> pop the requester not equal to LAST;
  - on every pop: LAST<=granted requester, RF_WRITE<=1, RF_ADDR/RF_DATA<=popped entry.
- Arbiter states: IDLE (RF_WRITE=0), GNT_ALU, GNT_MEM. The next state is chosen by the rules above each cycle.
- Latency: request accepted at edge N into an empty FIFO with no contention -> popped at edge N+1 -> RF_WRITE=1 during cycle N+1..N+2 -> register file samples at edge N+2. There is no bypass path.
- Throughput: one RF write per cycle. Under continuous contention the requesters alternate strictly.
- FLUSH=1 at an edge:
  - both FIFOs cleared, no pop, RF_WRITE<=0;
  - any push presented in that cycle is dropped, but the handshake still completes if READY=1;
  - LAST unchanged.
- BUSY:
  - RDx_BUSY=1 iff RDx_ADDR!=0 and it matches a valid entry in either FIFO, or matches RF_ADDR while RF_WRITE=1.
  - The second term covers the register file's write delay.
  - Combinational from registered state and RDx_ADDR only.
- Ordering: commit order equals arbitration order. The pipeline guarantees no same-register write-after-write between requesters while both are in flight. Within one requester, order is FIFO order.

Test Plan:
- Reset then ALU_VALID=1, ALU_ADDR=3, ALU_DATA=0x5F for one cycle -> RF_WRITE=1, RF_ADDR=3, RF_DATA=0x5F exactly one cycle after acceptance, then RF_WRITE=0; RD1_ADDR=3 shows BUSY=1 from acceptance through the RF_WRITE cycle, then 0.
- Both requesters push every cycle (ALU to r1, data 10,11,...; MEM to r2, data 20,21,...) -> RF writes alternate MEM(20), ALU(10), MEM(21), ALU(11); READY deasserts when a count reaches 2 and never overflows.
- MEM holds VALID=1 with no pops possible beyond one per cycle, filling QDEPTH=2 entries -> MEM_READY=0 in the cycle the count is 2, even while that FIFO is being popped; it returns to 1 the cycle after the count drops.
- ALU_VALID=1, ALU_ADDR=0, ALU_DATA=0xFFFF -> ALU_READY stays 1, no RF_WRITE, RD1_ADDR=0 gives BUSY=0.
- Queue 2 ALU and 1 MEM entries, then FLUSH=1 for one edge -> RF_WRITE=0 next cycle, both READY=1, all BUSY=0, no further writes.
- Assert RESET=0 asynchronously mid-cycle while RF_WRITE=1 with 3 entries queued -> RF_WRITE, RF_ADDR and RF_DATA go to 0 immediately; after release, no stale writes appear.
